// File: rtl/pattern_serializer_if.sv
// Parallel pattern handshake into the serializer: producer offers a word, serializer accepts when ready.
interface pattern_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = $clog2(WIDTH) + 1
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic             in_ready;

  modport master (output in_valid, output in_data, output in_len, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_len, output in_ready);
endinterface

// File: rtl/pattern_serializer.sv
// Shifts an accepted pattern word out MSB-first on a single data line, then
// holds a run of zero gap cycles so consecutive patterns stay framed.
module pattern_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned LW         = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  pattern_serializer_if.slave  in_if,
  output logic                 data,
  output logic                 data_valid,
  output logic                 last,
  output logic                 busy,
  output logic [1:0]           state_out
);

  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [LW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] aligned;

  // Zero or oversize lengths mean a full-width pattern; left-align so the first bit sits at the MSB.
  always_comb begin
    eff_len = in_if.in_len;
    if ((in_if.in_len == LW'(0)) || (in_if.in_len > LW'(WIDTH))) begin
      eff_len = LW'(WIDTH);
    end
    aligned = in_if.in_data << (LW'(WIDTH) - eff_len);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      in_if.in_ready <= 1'b1;
      state_out  <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_if.in_valid) begin
            state          <= SHIFT;
            sr             <= aligned;
            bit_cnt        <= eff_len;
            data           <= aligned[WIDTH-1];
            data_valid     <= 1'b1;
            last           <= (eff_len == LW'(1));
            busy           <= 1'b1;
            in_if.in_ready <= 1'b0;
            state_out      <= SHIFT;
          end
        end

        SHIFT: begin
          sr      <= sr << 1;
          bit_cnt <= bit_cnt - LW'(1);
          if (bit_cnt <= LW'(1)) begin
            data       <= 1'b0;
            data_valid <= 1'b0;
            last       <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state          <= IDLE;
              busy           <= 1'b0;
              in_if.in_ready <= 1'b1;
              state_out      <= IDLE;
            end else begin
              state     <= GAP;
              gap_cnt   <= GW'(GAP_CYCLES);
              state_out <= GAP;
            end
          end else begin
            // Outputs present the bit that will be the MSB after this shift.
            data <= sr[WIDTH-2];
            last <= (bit_cnt == LW'(2));
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt <= GW'(1)) begin
            state          <= IDLE;
            busy           <= 1'b0;
            in_if.in_ready <= 1'b1;
            state_out      <= IDLE;
          end
        end

        default: begin
          state          <= IDLE;
          sr             <= '0;
          bit_cnt        <= '0;
          gap_cnt        <= '0;
          data           <= 1'b0;
          data_valid     <= 1'b0;
          last           <= 1'b0;
          busy           <= 1'b0;
          in_if.in_ready <= 1'b1;
          state_out      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: one instance with a two-cycle gap, one with no gap.
module tb_pattern_serializer;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pattern_serializer_if #(.WIDTH(8)) if2 ();
  pattern_serializer_if #(.WIDTH(8)) if0 ();

  logic       data2, dv2, last2, busy2;
  logic [1:0] st2;
  logic       data0, dv0, last0, busy0;
  logic [1:0] st0;

  pattern_serializer #(.WIDTH(8), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_if(if2),
    .data(data2), .data_valid(dv2), .last(last2), .busy(busy2), .state_out(st2)
  );

  pattern_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_if(if0),
    .data(data0), .data_valid(dv0), .last(last0), .busy(busy0), .state_out(st0)
  );

  // Observed outputs packed as {in_ready, data, data_valid, last, busy, state_out}.
  function automatic logic [6:0] observe(input bit sel);
    if (sel) return {if0.in_ready, data0, dv0, last0, busy0, st0};
    return {if2.in_ready, data2, dv2, last2, busy2, st2};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic [3:0] l);
    if (sel) begin
      if0.in_valid = v; if0.in_data = d; if0.in_len = l;
    end else begin
      if2.in_valid = v; if2.in_data = d; if2.in_len = l;
    end
  endtask

  // Offers one word at the current negedge, then checks every cycle of its
  // bits, its gap, and the idle cycle that follows, while pushing junk words
  // that must be ignored.
  task automatic run_word(input bit sel, input logic [7:0] d, input logic [3:0] l);
    int         len;
    int         gap;
    logic [6:0] exp;
    len = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    gap = sel ? 0 : 2;
    drive(sel, 1'b1, d, l);
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= len + gap + 1; k++) begin
      if (k <= len)            exp = {1'b0, d[len-k], 1'b1, (k == len), 1'b1, 2'd1};
      else if (k <= len + gap) exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
      else                     exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      chk($sformatf("g%0d d=%02h l=%0d k=%0d", gap, d, l, k), observe(sel), exp);
      if (k < len + gap + 1) begin
        drive(sel, 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));
        @(negedge clk);
      end else begin
        drive(sel, 1'b0, 8'($urandom), 4'd0);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    drive(1'b1, 1'b0, 8'h00, 4'd0);
    repeat (2) @(negedge clk);
    chk("reset_g2", observe(1'b0), 7'b1_0_0_0_0_00);
    chk("reset_g0", observe(1'b1), 7'b1_0_0_0_0_00);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_g2", observe(1'b0), 7'b1_0_0_0_0_00);

    // Directed patterns with gap, including length coercion.
    run_word(1'b0, 8'h95, 4'd8);
    run_word(1'b0, 8'hFD, 4'd3);
    run_word(1'b0, 8'hA7, 4'd0);
    run_word(1'b0, 8'h3C, 4'd15);
    run_word(1'b0, 8'h81, 4'd1);

    // Back-to-back without gap, ending with a 4-bit tail 0100.
    run_word(1'b1, 8'h95, 4'd8);
    run_word(1'b1, 8'h95, 4'd8);
    run_word(1'b1, 8'h04, 4'd4);

    for (int i = 0; i < 24; i++) begin
      run_word(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));
    end

    // Asynchronous reset during bit index 4 of 8'h95.
    drive(1'b0, 1'b1, 8'h95, 4'd8);
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("pre_reset_bit4", observe(1'b0), 7'b0_0_1_0_1_01);
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    #2 rstn = 1'b0;
    #1 chk("async_reset", observe(1'b0), 7'b1_0_0_0_0_00);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", observe(1'b0), 7'b1_0_0_0_0_00);
    run_word(1'b0, 8'hC6, 4'd8);
    run_word(1'b0, 8'($urandom), 4'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Serial stimulus source for the bit-stream sequence detector. Accepts a parallel pattern word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single-bit `data` line that connects directly to the detector's `data` input. An idle gap of zeros follows each pattern so consecutive patterns are framed. Used in detector testbenches and as the on-chip pattern source.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `GAP_CYCLES`, 2: number of forced-zero cycles after each pattern (0 allowed).
- `LW`, $clog2(WIDTH)+1: width of `in_len` (derived; do not override).

- `clk`  input  1  rising-edge clock; the only clock.
- `rstn`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  pattern word offered.
- `in_data`  input  WIDTH  pattern; the `in_len` LSBs are used, highest used bit sent first.
- `in_len`  input  LW  number of bits to send; 0 or >WIDTH means WIDTH.
- `in_ready`  output  1  block accepts a word this cycle.
- `data`  output  1  serial bit to the detector.
- `data_valid`  output  1  `data` carries a pattern bit, not a gap or idle zero.
- `last`  output  1  current `data` bit is the pattern's final bit.
- `busy`  output  1  high in SHIFT or GAP.
- `state_out`  output  2  current state encoding.

## Operation
- States: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2. 2'd3 is unreachable and recovers to IDLE on the next clock.
- IDLE: `in_ready`=1, `data`=0. On `in_valid && in_ready`:
  - latch `in_data` into the shift register, left-aligned so bit (len-1) becomes the MSB;
  - load the bit counter with the effective length L;
  - go to SHIFT.
- SHIFT:
  - `data`=shift register MSB, `data_valid`=1; shift left by one each clock; decrement the counter.
  - `last`=1 when counter==1.
  - After the last bit: go to GAP with gap counter=GAP_CYCLES, or straight to IDLE if GAP_CYCLES==0.
- GAP: `data`=0, `data_valid`=0; decrement the gap counter; go to IDLE when it reaches the final gap cycle.
- `in_ready` is 0 in SHIFT and GAP. `in_valid` there is ignored, and the word is not captured.
- `in_data`/`in_len` are sampled only on the accept edge; later changes have no effect.
- Reset (asynchronous, at any time including mid-SHIFT):
  - state=IDLE; shift register and counters 0;
  - `data`=0, `data_valid`=0, `last`=0, `busy`=0, `in_ready`=1, `state_out`=2'd0.
  - The partial pattern is discarded and not resumed after reset deasserts.

## Timing
- All outputs are registered or decoded from state/registers only. There is no combinational path from `in_*` to any output.
- Accept at edge T → first bit on `data` during cycle T+1 → bit k (0-based) during T+1+k → `last` during T+L.
- GAP occupies cycles T+L+1 … T+L+GAP_CYCLES; `in_ready` reasserts at T+L+GAP_CYCLES+1.
- Minimum accept-to-accept spacing: L+GAP_CYCLES+1 cycles.
- With GAP_CYCLES=0, patterns are separated by exactly one idle zero cycle, which is the IDLE accept cycle.
- `data` changes only after a rising `clk` edge, so it is stable around the detector's sampling edge.

## Test plan
- Basic pattern, WIDTH=8, GAP_CYCLES=2: `in_data`=8'h95, `in_len`=8 accepted at T.
  - `data` = 1,0,0,1,0,1,0,1 in T+1..T+8; `last` only at T+8; `data`=0 at T+9..T+10.
  - `in_ready`=1 again at T+11; `state_out` sequence 0,1×8,2×2,0.
- Short length: `in_data`=8'hFD, `in_len`=3 → `data` = 1,0,1 in T+1..T+3; upper bits never appear; `last` at T+3.
- Length coercion: `in_len`=0, then `in_len`=15 → all 8 bits sent each time, MSB first.
- Busy rejection: hold `in_valid`=1 with changing `in_data` throughout SHIFT/GAP.
  - Only the first word is sent; the next word is accepted exactly at T+11.
  - Back-to-back: with GAP_CYCLES=0, the second word's first bit appears at T+10.
- Reset mid-operation: assert `rstn`=0 asynchronously during bit 4 of 8'h95.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release, `in_ready`=1 and the next word transmits from its MSB.
- Detector end-to-end: drive detector `data` with the serializer output.
  - Send 8'h95 then 12-bit-equivalent patterns split as 8'h95 + 4'b0100.
  - Detector `out` pulses match the bench's reference model of the serial stream cycle-for-cycle.
